uart_baud_gen: RTL and testbench
================================

Name: uart_baud_gen

Overview:
- Parametrised, runtime-programmable baud/bit timer for the UART TX and RX paths.
- Successor to the fixed-count TX bit timer:
  - divisor loadable at run time, with a fractional part for low baud error;
  - oversample tick for RX;
  - bit index and frame-done tracking across a full start+data+stop frame.
- Sits between the register/config block and the uart_tx/uart_rx FSMs.

Parameters:
- DIV_WIDTH, 16: width of the integer oversample divisor.
- FRAC_WIDTH, 4: width of the fractional divisor; fraction = div_frac / 2^FRAC_WIDTH.
- OVERSAMPLE, 16: oversample ticks per bit; must be ≥2 and a power of two.
- FRAME_WIDTH, 8: data bits per frame.
- BITS_WIDTH, FRAME_WIDTH+2: bits per frame (start + data + stop).
- DEFAULT_DIV_INT, 651: integer divisor after reset (100 MHz / (9600*16)).
- DEFAULT_DIV_FRAC, 1: fractional divisor after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- cnt_en  in  1  run enable; low holds and clears all timing state.
- div_load  in  1  one-cycle strobe capturing div_int_in/div_frac_in.
- div_int_in  in  DIV_WIDTH  new integer divisor.
- div_frac_in  in  FRAC_WIDTH  new fractional divisor.
- os_tick  out  1  one-cycle pulse per oversample period.
- bit_tick  out  1  one-cycle pulse per bit period.
- frame_done  out  1  one-cycle pulse on the last bit_tick of a frame.
- bit_idx  out  $clog2(BITS_WIDTH)  index of the bit in progress, 0..BITS_WIDTH-1.

Behaviour:
- Reset (rst=0, asynchronous):
  - os_tick, bit_tick, frame_done, bit_idx all 0.
  - Internal counters and fractional accumulator cleared.
  - Active and shadow divisors set to DEFAULT_DIV_INT / DEFAULT_DIV_FRAC.
- All outputs are registered.
- Oversample period: P = div_int + c.
  - c = carry out of (acc + div_frac), evaluated at the start of each period.
  - acc <= low FRAC_WIDTH bits of that sum at the os_tick closing the period.
  - Sum is computed at FRAC_WIDTH+1 bits; no overflow is possible.
- Divisor clamp: div_int < 2 is treated as 2. The 0/1 values are never used as a period.
- Timing: with cnt_en first sampled high at edge 1, os_tick is high for exactly one cycle after edge P. It then repeats every period for as long as cnt_en stays high.
- bit_tick: coincides with every OVERSAMPLE-th os_tick. The internal os count is OVERSAMPLE-sized and wraps at OVERSAMPLE-1 -> 0.
- bit_idx:
  - Increments on each bit_tick.
  - On the bit_tick where bit_idx == BITS_WIDTH-1: frame_done pulses with that bit_tick and bit_idx wraps to 0.
  - Counting continues seamlessly for back-to-back frames.
- cnt_en low:
  - Next edge clears the clk count, os count, bit_idx and acc.
  - All tick outputs go 0; no partial-period tick is ever emitted.
  - Re-asserting cnt_en restarts a full first period.
- div_load:
  - Always captures into shadow registers; the latest strobe wins.
  - Idle (cnt_en=0): shadow is copied to active on the next edge.
  - Running: shadow is copied to active on the next bit_tick edge, so no bit is ever timed with mixed divisors.
  - div_load in the same cycle as bit_tick: the new value is applied at that boundary.
- Simultaneous div_load and cnt_en falling: the load is captured and applied, and the counters clear.
- Reset mid-frame aborts immediately. No tick is issued until a full period elapses after re-enable.

Optional Feature:
- Macro: UART_BAUD_MID_TICK_EN.
- Defined:
  - Adds output port mid_tick (1 bit), a one-cycle pulse on the os_tick where os count == OVERSAMPLE/2 - 1.
  - This marks the bit centre for RX sampling.
  - Reset value 0; cleared with cnt_en low, like the other ticks.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset defaults: assert rst=0 while cnt_en=1 -> all outputs 0. Release, run -> first os_tick 651 cycles after cnt_en sampled (acc=0, 0+1 no carry).
- Integer divide: OVERSAMPLE=4, BITS_WIDTH=10, load div_int=4, div_frac=0 while idle, cnt_en=1 ->
  - os_tick every 4 clk;
  - bit_tick every 16 clk;
  - frame_done once per 160 clk, together with bit_idx 9 -> 0.
- Fractional divide: div_int=3, div_frac=8 (FRAC_WIDTH=4) -> os_tick intervals 3,4,3,4,..., i.e. 7 clk per 2 ticks exactly over 64 ticks.
- Clamp: load div_int=0, then div_int=1 -> os_tick every 2 clk in both cases; never stuck, never every cycle.
- Mid-run load: running div_int=4, strobe div_int=8 mid-bit -> remaining os_ticks of that bit keep 4 clk spacing. The first 8-clk period begins right after the next bit_tick.
- Enable drop: drop cnt_en for 1 cycle mid-bit (bit_idx=3) -> bit_idx=0 and no ticks next cycle. Re-enable -> first os_tick a full P later. With UART_BAUD_MID_TICK_EN, mid_tick fires on the 2nd os_tick of each bit (OVERSAMPLE=4).

Source files
------------

// File: rtl/uart_baud_gen.sv
// Runtime-programmable UART baud timer: fractional oversample divider, bit/frame tracking.
// Optional mid-bit RX sample strobe (mid_tick) when UART_BAUD_MID_TICK_EN is defined.
module uart_baud_gen #(
    parameter int DIV_WIDTH        = 16,
    parameter int FRAC_WIDTH       = 4,
    parameter int OVERSAMPLE       = 16,
    parameter int FRAME_WIDTH      = 8,
    parameter int BITS_WIDTH       = FRAME_WIDTH + 2,
    parameter int DEFAULT_DIV_INT  = 651,
    parameter int DEFAULT_DIV_FRAC = 1,
    localparam int IDX_WIDTH       = $clog2(BITS_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cnt_en,
    input  logic                  div_load,
    input  logic [DIV_WIDTH-1:0]  div_int_in,
    input  logic [FRAC_WIDTH-1:0] div_frac_in,
    output logic                  os_tick,
    output logic                  bit_tick,
    output logic                  frame_done,
`ifdef UART_BAUD_MID_TICK_EN
    output logic                  mid_tick,
`endif
    output logic [IDX_WIDTH-1:0]  bit_idx
);

    localparam int OS_WIDTH = $clog2(OVERSAMPLE);

    localparam logic [DIV_WIDTH-1:0]  DIV_MIN   = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0]  DIV_RST   = DIV_WIDTH'(DEFAULT_DIV_INT);
    localparam logic [FRAC_WIDTH-1:0] FRAC_RST  = FRAC_WIDTH'(DEFAULT_DIV_FRAC);
    localparam logic [OS_WIDTH-1:0]   OS_LAST   = OS_WIDTH'(OVERSAMPLE - 1);
    localparam logic [IDX_WIDTH-1:0]  IDX_LAST  = IDX_WIDTH'(BITS_WIDTH - 1);
`ifdef UART_BAUD_MID_TICK_EN
    localparam logic [OS_WIDTH-1:0]   OS_MID    = OS_WIDTH'(OVERSAMPLE / 2 - 1);
`endif

    logic [DIV_WIDTH-1:0]  shadow_int,  shadow_int_nxt;
    logic [FRAC_WIDTH-1:0] shadow_frac, shadow_frac_nxt;
    logic [DIV_WIDTH-1:0]  active_int;
    logic [FRAC_WIDTH-1:0] active_frac;

    logic [DIV_WIDTH-1:0]  clk_cnt;
    logic [OS_WIDTH-1:0]   os_cnt;
    logic [FRAC_WIDTH-1:0] acc;

    logic [DIV_WIDTH-1:0]  div_eff;
    logic [FRAC_WIDTH:0]   frac_sum;
    logic [DIV_WIDTH-1:0]  period_last;
    logic                  os_fire;
    logic                  bit_fire;
    logic                  frame_fire;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        shadow_int_nxt  = shadow_int;
        shadow_frac_nxt = shadow_frac;
        if (div_load) begin
            shadow_int_nxt  = div_int_in;
            shadow_frac_nxt = div_frac_in;
        end

        div_eff     = (active_int < DIV_MIN) ? DIV_MIN : active_int;
        frac_sum    = {1'b0, acc} + {1'b0, active_frac};
        // Carry stretches this period by one clock; max value still fits DIV_WIDTH.
        period_last = div_eff - DIV_WIDTH'(1) + DIV_WIDTH'(frac_sum[FRAC_WIDTH]);

        os_fire    = cnt_en && (clk_cnt == period_last);
        bit_fire   = os_fire && (os_cnt == OS_LAST);
        frame_fire = bit_fire && (bit_idx == IDX_LAST);
    end

    // Active divisor only changes while idle or on the edge where bit_tick is high;
    // that edge is the first of the next bit, so each bit sees one divisor only.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_int  <= DIV_RST;
            shadow_frac <= FRAC_RST;
            active_int  <= DIV_RST;
            active_frac <= FRAC_RST;
        end else begin
            shadow_int  <= shadow_int_nxt;
            shadow_frac <= shadow_frac_nxt;
            if (!cnt_en || bit_tick) begin
                active_int  <= shadow_int_nxt;
                active_frac <= shadow_frac_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_cnt    <= '0;
            os_cnt     <= '0;
            acc        <= '0;
            bit_idx    <= '0;
            os_tick    <= 1'b0;
            bit_tick   <= 1'b0;
            frame_done <= 1'b0;
`ifdef UART_BAUD_MID_TICK_EN
            mid_tick   <= 1'b0;
`endif
        end else if (!cnt_en) begin
            clk_cnt    <= '0;
            os_cnt     <= '0;
            acc        <= '0;
            bit_idx    <= '0;
            os_tick    <= 1'b0;
            bit_tick   <= 1'b0;
            frame_done <= 1'b0;
`ifdef UART_BAUD_MID_TICK_EN
            mid_tick   <= 1'b0;
`endif
        end else begin
            os_tick    <= os_fire;
            bit_tick   <= bit_fire;
            frame_done <= frame_fire;
`ifdef UART_BAUD_MID_TICK_EN
            mid_tick   <= os_fire && (os_cnt == OS_MID);
`endif
            if (os_fire) begin
                clk_cnt <= '0;
                acc     <= frac_sum[FRAC_WIDTH-1:0];
                os_cnt  <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_WIDTH'(1);
            end else begin
                clk_cnt <= clk_cnt + DIV_WIDTH'(1);
            end
            if (bit_fire) begin
                bit_idx <= frame_fire ? '0 : bit_idx + IDX_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen (OVERSAMPLE=4, 10-bit frames); mid_tick checked
// when UART_BAUD_MID_TICK_EN is defined.
module tb_uart_baud_gen;

    localparam int DIV_WIDTH  = 16;
    localparam int FRAC_WIDTH = 4;
    localparam int OS         = 4;
    localparam int BITS       = 10;
    localparam int LIMIT      = 2000;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cnt_en;
    logic                  div_load;
    logic [DIV_WIDTH-1:0]  div_int_in;
    logic [FRAC_WIDTH-1:0] div_frac_in;
    logic                  os_tick;
    logic                  bit_tick;
    logic                  frame_done;
    logic [3:0]            bit_idx;
`ifdef UART_BAUD_MID_TICK_EN
    logic                  mid_tick;
`endif

    int n_vec = 0;
    int n_err = 0;

    uart_baud_gen #(
        .DIV_WIDTH(DIV_WIDTH),
        .FRAC_WIDTH(FRAC_WIDTH),
        .OVERSAMPLE(OS),
        .FRAME_WIDTH(8),
        .BITS_WIDTH(BITS),
        .DEFAULT_DIV_INT(651),
        .DEFAULT_DIV_FRAC(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cnt_en(cnt_en),
        .div_load(div_load),
        .div_int_in(div_int_in),
        .div_frac_in(div_frac_in),
        .os_tick(os_tick),
        .bit_tick(bit_tick),
        .frame_done(frame_done),
`ifdef UART_BAUD_MID_TICK_EN
        .mid_tick(mid_tick),
`endif
        .bit_idx(bit_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_os(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!os_tick && n < LIMIT);
    endtask

    task automatic idle_load(input int d_int, input int d_frac);
        cnt_en      = 1'b0;
        div_load    = 1'b1;
        div_int_in  = DIV_WIDTH'(d_int);
        div_frac_in = FRAC_WIDTH'(d_frac);
        step();
        div_load = 1'b0;
        step();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_os"}, int'(os_tick), 0);
        check({tag, "_bit"}, int'(bit_tick), 0);
        check({tag, "_frame"}, int'(frame_done), 0);
        check({tag, "_idx"}, int'(bit_idx), 0);
`ifdef UART_BAUD_MID_TICK_EN
        check({tag, "_mid"}, int'(mid_tick), 0);
`endif
    endtask

    initial begin
        int n;
        int total;

        // Reset held with cnt_en high: everything quiet.
        rst         = 1'b0;
        cnt_en      = 1'b1;
        div_load    = 1'b0;
        div_int_in  = '0;
        div_frac_in = '0;
        #2;
        check_quiet("reset");
        step();
        step();
        check_quiet("reset_hold");
        rst = 1'b1;
        wait_os(n);
        check("default_first_os", n, 651);

        // Integer divide 4/0: two back-to-back frames, every cycle checked.
        idle_load(4, 0);
        cnt_en = 1'b1;
        for (int i = 1; i <= 330; i++) begin
            step();
            check("int_os", int'(os_tick), int'(i % 4 == 0));
            check("int_bit", int'(bit_tick), int'(i % 16 == 0));
            check("int_frame", int'(frame_done), int'(i % 160 == 0));
            check("int_idx", int'(bit_idx), (i / 16) % BITS);
`ifdef UART_BAUD_MID_TICK_EN
            check("int_mid", int'(mid_tick), int'(i % 16 == 8));
`endif
        end

        // Fractional 3 + 8/16: intervals alternate 3,4; 64 ticks take 224 clocks.
        idle_load(3, 8);
        cnt_en = 1'b1;
        total  = 0;
        for (int k = 1; k <= 64; k++) begin
            wait_os(n);
            total += n;
            check("frac_interval", n, (k % 2 == 1) ? 3 : 4);
        end
        check("frac_total", total, 224);

        // Clamp: 0 and 1 both behave as 2.
        idle_load(0, 0);
        cnt_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_os(n);
            check("clamp0_interval", n, 2);
        end
        idle_load(1, 0);
        cnt_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_os(n);
            check("clamp1_interval", n, 2);
        end

        // Mid-bit load of 8 while running at 4: takes effect from the next bit.
        idle_load(4, 0);
        cnt_en = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            step();
            if (i == 22) begin
                div_load   = 1'b1;
                div_int_in = DIV_WIDTH'(8);
            end else begin
                div_load = 1'b0;
            end
            check("midload_os", int'(os_tick),
                  int'((i <= 32) ? (i % 4 == 0) : ((i - 32) % 8 == 0)));
            check("midload_bit", int'(bit_tick), int'(i == 16 || i == 32 || i == 64));
        end

        // Enable drop for one cycle while bit_idx == 3.
        idle_load(4, 0);
        cnt_en = 1'b1;
        for (int i = 1; i <= 50; i++) step();
        check("drop_pre_idx", int'(bit_idx), 3);
        cnt_en = 1'b0;
        step();
        check_quiet("drop");
        cnt_en = 1'b1;
        wait_os(n);
        check("drop_restart_os", n, 4);
        check("drop_restart_idx", int'(bit_idx), 0);

        // Load coinciding with cnt_en falling is still applied.
        cnt_en     = 1'b0;
        div_load   = 1'b1;
        div_int_in = DIV_WIDTH'(6);
        step();
        div_load = 1'b0;
        check("fall_load_os", int'(os_tick), 0);
        cnt_en = 1'b1;
        wait_os(n);
        check("fall_load_interval", n, 6);

        // Reset mid-frame: immediate abort, defaults restored.
        for (int i = 0; i < 30; i++) step();
        check("rst_pre_idx", int'(bit_idx), 1);
        rst = 1'b0;
        #1;
        check_quiet("rst_mid");
        step();
        rst = 1'b1;
        wait_os(n);
        check("rst_restart_os", n, 651);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
